// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and constants for the memory-stage SRAM controller
package mem_stage_pkg;
    localparam int unsigned DEF_BASE_ADDR = 1024;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned CNT_W = 4;
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_e;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: per-phase down-counter, loads WAIT_CYCLES-1 and flags the final cycle
module sram_wait_counter
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic last_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // reload at phase entry, otherwise count down and park at zero
    always_comb cnt_d = load_i ? CNT_W'(WAIT_CYCLES - 1) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    // counter register
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign last_o = cnt_q == '0;
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: 32-bit load/store as two 16-bit SRAM accesses; optional MEM_ALIGN_CHECK_EN
module mem_stage_sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        val_rm,
    output logic [31:0]        mem_rdata,
    output logic               freeze,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               align_err
);
    state_e state_q, state_d;
    logic [SRAM_DW-1:0] lo_q;
    logic [31:0] rdata_q, eff;
    logic [ADDR_W-2:0] idx;
    logic req, misal, go, last, lo_ph, hi_ph, unused_bits;
    assign eff = alu_res - 32'(BASE_ADDR);
    assign idx = eff[ADDR_W:2];
    assign unused_bits = ^{eff[31:ADDR_W+1], eff[1:0]};
    assign req = mem_r_en | mem_w_en;
`ifdef MEM_ALIGN_CHECK_EN
    logic align_q;
    assign misal = alu_res[1:0] != 2'b00;
    // one-cycle flag for a rejected misaligned request
    always_ff @(posedge clk or negedge rst)
        if (!rst) align_q <= 1'b0;
        else align_q <= state_q == IDLE && req && misal;
    assign align_err = align_q;
`else
    assign misal = 1'b0;
    assign align_err = 1'b0;
`endif
    // rst gating keeps freeze low while reset is held with a request pending
    assign go = rst && state_q == IDLE && req && !misal;
    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (go || (last && (state_q == RD_LO || state_q == WR_LO))),
        .last_o (last)
    );
    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;
    // next state: read wins over write; each half phase ends on the counter's last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? (mem_r_en ? RD_LO : WR_LO) : IDLE;
            RD_LO:   state_d = last ? RD_HI : RD_LO;
            RD_HI:   state_d = last ? DONE : RD_HI;
            WR_LO:   state_d = last ? WR_HI : WR_LO;
            WR_HI:   state_d = last ? DONE : WR_HI;
            default: state_d = IDLE;
        endcase
    end
    // SRAM strobes and address decode straight from state so reset releases them asynchronously
    always_comb begin
        lo_ph = state_q == RD_LO || state_q == WR_LO;
        hi_ph = state_q == RD_HI || state_q == WR_HI;
        freeze = go || lo_ph || hi_ph;
        sram_addr = lo_ph ? {idx, 1'b0} : hi_ph ? {idx, 1'b1} : '0;
        sram_wdata = state_q == WR_LO ? val_rm[15:0] : state_q == WR_HI ? val_rm[31:16] : '0;
        sram_we_n = !(state_q == WR_LO || state_q == WR_HI);
        sram_oe_n = !(state_q == RD_LO || state_q == RD_HI);
    end
    // low half is staged so mem_rdata only changes when the whole word is in
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            lo_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == RD_LO && last) lo_q <= sram_rdata;
            if (state_q == RD_HI && last) rdata_q <= {sram_rdata, lo_q};
        end
    assign mem_rdata = rdata_q;
endmodule
